// File: rtl/bytecode_pkg.sv
// Shared definitions for bytecode fetch and decode.
// Fetch FSM states, opcode constants and instruction-length rule.
package bytecode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAP,
        OUT
    } fetch_state_t;

    localparam logic [7:0] OP_BIPUSH = 8'h10;
    localparam logic [7:0] OP_SIPUSH = 8'h11;
    localparam logic [7:0] OP_IINC   = 8'h84;
    localparam logic [7:0] OP_GOTO   = 8'hA7;
    localparam logic [7:0] OP_RETURN = 8'hB1;

    function automatic logic [1:0] instr_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (op == OP_SIPUSH || op == OP_IINC || op == OP_GOTO ||
            (op >= 8'h99 && op <= 8'hA8)) begin
            len = 2'd3;
        end else if (op == OP_BIPUSH ||
                     (op >= 8'h15 && op <= 8'h19) ||
                     (op >= 8'h36 && op <= 8'h3A)) begin
            len = 2'd2;
        end
        return len;
    endfunction

endpackage

// File: rtl/bytecode_fetch_ctrl_lut.sv
// Combinational opcode to instruction-length mapping.
// Shared between the fetch controller and the decoder.
module opcode_len_lut
    import bytecode_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = instr_len(opcode);

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Byte-serial bytecode fetch: one ROM read per byte, assembles
// 1..3 byte instructions and hands them over on valid/ready.
module bytecode_fetch_ctrl
    import bytecode_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            instr_opcode,
    output logic [15:0]           instr_operands,
    output logic [1:0]            instr_len,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

    fetch_state_t          state, state_d;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            byte_idx;
    logic [1:0]            lut_len;
    logic [1:0]            cur_len;
    logic [7:0]            byte_in;
    logic                  more;
    logic                  accept;

    assign byte_in = rom_data[7:0];

    opcode_len_lut u_lut (
        .opcode (byte_in),
        .len    (lut_len)
    );

    // Length is only known from the LUT while the opcode byte is on the bus.
    assign cur_len  = (byte_idx == 2'd0) ? lut_len : instr_len;
    assign more     = ({1'b0, byte_idx} + 3'd1) < {1'b0, cur_len};
    assign accept   = (state == OUT) && instr_ready;
    assign rom_addr = pc + ADDR_WIDTH'(byte_idx);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (run && !halted) state_d = REQ;
            REQ:  state_d = CAP;
            CAP:  state_d = more ? REQ : OUT;
            OUT: begin
                if (accept) begin
                    if (instr_opcode == OP_RETURN) state_d = IDLE;
                    else if (run)                  state_d = REQ;
                    else                           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) state_d = run ? REQ : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            byte_idx       <= 2'd0;
            rom_en         <= 1'b0;
            instr_valid    <= 1'b0;
            instr_opcode   <= 8'h00;
            instr_operands <= 16'h0000;
            instr_len      <= 2'd0;
            instr_pc       <= '0;
            halted         <= 1'b0;
        end else begin
            state       <= state_d;
            rom_en      <= (state_d == REQ);
            instr_valid <= (state_d == OUT);
            if (redirect_valid) begin
                pc       <= redirect_pc;
                byte_idx <= 2'd0;
                halted   <= 1'b0;
            end else if (state == CAP) begin
                unique case (byte_idx)
                    2'd0: begin
                        instr_opcode   <= byte_in;
                        instr_len      <= lut_len;
                        instr_operands <= 16'h0000;
                        instr_pc       <= pc;
                    end
                    2'd1:    instr_operands[15:8] <= byte_in;
                    default: instr_operands[7:0]  <= byte_in;
                endcase
                if (more) byte_idx <= byte_idx + 2'd1;
            end else if (accept) begin
                pc       <= pc + ADDR_WIDTH'(instr_len);
                byte_idx <= 2'd0;
                if (instr_opcode == OP_RETURN) halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Directed and randomized checks of bytecode_fetch_ctrl against
// an instruction-level model of the ROM program.
module tb_bytecode_fetch_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [7:0]    instr_opcode;
    logic [15:0]   instr_operands;
    logic [1:0]    instr_len;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halted;

    logic [7:0] mem [0:1023];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int hs0;

    bytecode_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_operands (instr_operands),
        .instr_len      (instr_len),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    always @(posedge clk)
        if (instr_valid && instr_ready) hs_count <= hs_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA8))
            return 3;
        if (op == 8'h10 || (op >= 8'h15 && op <= 8'h19) ||
            (op >= 8'h36 && op <= 8'h3A))
            return 2;
        return 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_opcode"}, instr_opcode, 0);
        chk({tag, "_operands"}, instr_operands, 0);
        chk({tag, "_len"}, instr_len, 0);
        chk({tag, "_pc"}, instr_pc, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    task automatic redirect(input logic [AW-1:0] tgt);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Walk the program from start, expecting n instructions in order.
    task automatic stream(input logic [AW-1:0] start, input int n,
                          input bit rnd);
        logic [AW-1:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            logic [7:0]    op;
            logic [AW-1:0] a1, a2;
            logic [15:0]   opnd;
            int            len;
            int            waited;
            bit            got;
            op = mem[pc];
            len = ref_len(op);
            a1 = pc + 10'd1;
            a2 = pc + 10'd2;
            opnd[15:8] = (len > 1) ? mem[a1] : 8'h00;
            opnd[7:0]  = (len > 2) ? mem[a2] : 8'h00;
            waited = 0;
            got = 0;
            while (!got && waited < 100) begin
                @(negedge clk);
                waited++;
                if (instr_valid) begin
                    chk("s_opcode", instr_opcode, op);
                    chk("s_operands", instr_operands, opnd);
                    chk("s_len", instr_len, len);
                    chk("s_pc", instr_pc, pc);
                end
                instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (instr_valid && instr_ready) got = 1;
            end
            if (!got) begin
                chk("s_timeout", 0, 1);
                return;
            end
            if (i > 0 && !rnd) chk("s_gap", waited, 2 * len + 1);
            if (op == 8'hB1) begin
                @(negedge clk);
                chk("s_halted", halted, 1);
                chk("s_halt_rom_en", rom_en, 0);
                return;
            end
            pc = pc + AW'(len);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h60; mem[3] = 8'hB1;

        // reset state
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        instr_ready = 1'b1;

        // basic program ending in return
        stream(10'h000, 3, 0);
        repeat (4) begin
            @(negedge clk);
            chk("halt_rom_en", rom_en, 0);
            chk("halt_flag", halted, 1);
            chk("halt_valid", instr_valid, 0);
        end

        // redirect during capture of byte 1
        mem[0] = 8'hA7; mem[1] = 8'h00; mem[2] = 8'h10;
        mem[16] = 8'h60; mem[17] = 8'hB1;
        redirect(10'h000);
        chk("rd_clear_halt", halted, 0);
        chk("rd_addr0", rom_addr, 10'h000);
        chk("rd_en0", rom_en, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rd_addr1", rom_addr, 10'h001);
        @(negedge clk);
        chk("rd_cap_en", rom_en, 0);
        hs0 = hs_count;
        redirect_valid = 1'b1;
        redirect_pc = 10'h010;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rd_target", rom_addr, 10'h010);
        chk("rd_target_en", rom_en, 1);
        chk("rd_valid_low", instr_valid, 0);
        chk("rd_no_xfer", hs_count, hs0);
        stream(10'h010, 2, 0);

        // backpressure
        mem[256] = 8'h11; mem[257] = 8'h12; mem[258] = 8'h34;
        mem[259] = 8'hB1;
        instr_ready = 1'b0;
        redirect(10'h100);
        wait_valid("bp");
        hs0 = hs_count;
        repeat (5) begin
            chk("bp_opcode", instr_opcode, 8'h11);
            chk("bp_operands", instr_operands, 16'h1234);
            chk("bp_len", instr_len, 3);
            chk("bp_pc", instr_pc, 10'h100);
            chk("bp_valid", instr_valid, 1);
            chk("bp_rom_en", rom_en, 0);
            @(negedge clk);
        end
        chk("bp_no_xfer", hs_count, hs0);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_one_xfer", hs_count, hs0 + 1);
        chk("bp_valid_low", instr_valid, 0);
        chk("bp_next_addr", rom_addr, 10'h103);
        chk("bp_next_en", rom_en, 1);
        stream(10'h103, 1, 0);

        // redirect in the same cycle as accepting return
        mem[896] = 8'hB1;
        mem[912] = 8'hB1;
        instr_ready = 1'b0;
        redirect(10'h380);
        wait_valid("rr");
        hs0 = hs_count;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h390;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rr_halted", halted, 0);
        chk("rr_xfer", hs_count, hs0 + 1);
        chk("rr_addr", rom_addr, 10'h390);
        chk("rr_en", rom_en, 1);
        chk("rr_valid", instr_valid, 0);
        repeat (6) @(negedge clk);
        chk("rr_later_halt", halted, 1);

        // randomized program and ready
        for (int i = 512; i < 768; i++) mem[i] = 8'($urandom_range(0, 255));
        redirect(10'h200);
        stream(10'h200, 20, 1);

        // address wrap
        instr_ready = 1'b1;
        mem[1023] = 8'h11; mem[0] = 8'hAB; mem[1] = 8'hCD; mem[2] = 8'hB1;
        redirect(10'h3FF);
        stream(10'h3FF, 1, 0);
        @(negedge clk);
        chk("wrap_next_addr", rom_addr, 10'h002);
        chk("wrap_next_en", rom_en, 1);
        repeat (6) @(negedge clk);
        chk("wrap_halt", halted, 1);

        // run drops mid-instruction
        mem[768] = 8'h84; mem[769] = 8'h01; mem[770] = 8'h02;
        redirect(10'h300);
        run = 1'b0;
        stream(10'h300, 1, 0);
        repeat (4) begin
            @(negedge clk);
            chk("stop_rom_en", rom_en, 0);
            chk("stop_valid", instr_valid, 0);
        end

        // async reset in REQ of byte 2
        run = 1'b1;
        redirect(10'h300);
        repeat (4) @(negedge clk);
        chk("rst_pre_addr", rom_addr, 10'h302);
        chk("rst_pre_en", rom_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_restart_addr", rom_addr, 10'h000);
        chk("rst_restart_en", rom_en, 1);
        run = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytecode_fetch_ctrl.md
# bytecode_fetch_ctrl

Sequencing controller that drives the byte-wide bytecode ROM and assembles variable-length JVM-style instructions for the decoder. It owns the program counter, issues one ROM read per byte, uses the opcode to determine instruction length (1–3 bytes), and presents a complete instruction on a valid/ready handshake. It sits between the bytecode ROM and the decode stage and accepts PC redirects from execute (branches, jumps).

## Interface
- DATA_WIDTH, 8, ROM byte width
- ADDR_WIDTH, 10, ROM address width (1024 bytes)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; fetch allowed while high
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM read address; data returns on rom_data the following cycle
- rom_data  in  DATA_WIDTH  ROM read data
- instr_valid  out  1  instruction available
- instr_ready  in  1  decoder accepts
- instr_opcode  out  8  opcode byte
- instr_operands  out  16  operand bytes; byte1 in [15:8], byte2 in [7:0], unused bytes zero
- instr_len  out  2  instruction length, 1..3
- instr_pc  out  ADDR_WIDTH  address of the opcode byte
- redirect_valid  in  1  one-cycle PC redirect
- redirect_pc  in  ADDR_WIDTH  redirect target
- halted  out  1  set after a `return` (0xB1) is accepted

## Operation
- States: IDLE, REQ, CAP, OUT.
- IDLE: rom_en=0. Go to REQ when run=1 and halted=0.
- REQ: rom_en=1, rom_addr = pc + byte_idx (mod 2^ADDR_WIDTH). Always go to CAP.
- CAP: latch rom_data into byte slot byte_idx.
  - If byte_idx=0, capture len = LUT(opcode).
  - If byte_idx+1 < len: byte_idx++, go to REQ; otherwise go to OUT.
- OUT: instr_valid=1, all instr_* outputs held stable. On instr_valid & instr_ready:
  - pc += len (wraps), byte_idx=0.
  - If opcode=0xB1: set halted, go to IDLE.
  - Else if run=1: go to REQ; otherwise go to IDLE.
- Length LUT:
  - 2 bytes: 0x10, 0x15–0x19, 0x36–0x3A.
  - 3 bytes: 0x11, 0x84, 0x99–0xA8.
  - All other opcodes: 1 byte.
- run falling mid-instruction: the current instruction completes and is presented; the block idles after its handshake.
- Redirect has priority over every state:
  - pc <= redirect_pc, byte_idx=0, in-flight ROM data discarded, halted cleared.
  - Next state is REQ if run=1, else IDLE.
  - instr_valid is low in the following cycle.
- Redirect in the same cycle as an OUT handshake: the transfer counts as accepted, and the redirect target overrides pc+len.
- Redirect in the same cycle as acceptance of 0xB1: redirect wins and halted stays 0.
- Reset values:
  - Internal: pc=RESET_PC, byte_idx=0, state IDLE.
  - Outputs: rom_en=0, rom_addr=RESET_PC, instr_valid=0, instr_opcode=0, instr_operands=0, instr_len=0, instr_pc=0, halted=0.
- Reset asserted mid-instruction: all of the above are restored immediately (asynchronous); no partial instruction is presented.

## Timing
- ROM read latency is 1 cycle: address issued in REQ, data sampled in CAP.
- Each byte costs 2 cycles (REQ+CAP).
- Latency from leaving IDLE to instr_valid: 2×len cycles. instr_valid rises in the cycle after the final CAP.
- Throughput with instr_ready tied high: one instruction per 2×len+1 cycles.
- Redirect takes effect at the next edge. The first ROM read of the target is issued the cycle after redirect_valid.
- rom_addr is combinational from pc/byte_idx. All other outputs are registered.

## Structure
- Package bytecode_pkg holds:
  - fetch state enum
  - opcode constants (OP_BIPUSH=0x10, OP_SIPUSH=0x11, OP_IINC=0x84, OP_GOTO=0xA7, OP_RETURN=0xB1)
  - instruction-length function
- Sub-module opcode_len_lut: purely combinational opcode → length mapping, shared with decode.
- bytecode_fetch_ctrl contains the FSM, PC, byte_idx and the output registers.

## Test plan
- ROM = 10 05 60 B1, run=1, instr_ready=1 → bench receives three instructions, then halted=1 and rom_en stays 0:
  - opcode 0x10, operands 0x0500, len 2, pc 0
  - opcode 0x60, len 1, pc 2
  - opcode 0xB1, pc 3
- Backpressure: hold instr_ready=0 for 5 cycles while in OUT → instr_* outputs are stable, rom_en=0, and exactly one transfer occurs when ready rises.
- ROM = A7 00 10 …; pulse redirect_valid with redirect_pc=0x010 during the CAP of byte 1 → no instruction is presented from 0x000, and the next rom_addr is 0x010.
- Wrap-around: RESET_PC=0x3FF, ROM[0x3FF]=0x11, ROM[0]=0xAB, ROM[1]=0xCD → instruction with pc 0x3FF, operands 0xABCD, len 3; next fetch is at 0x002.
- Drop run during the fetch of a 3-byte instruction → that instruction is still delivered, then the block returns to IDLE with rom_en=0.
- Assert rst_n=0 during REQ of byte 2 → all outputs take their reset values within the same cycle; after release with run=1, fetch restarts at RESET_PC.
